// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ahb_pkg
// Brief   : Shared AHB encodings, slave FSM states and lane-mask helper.
// Revision: 1.0 - initial release
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_t;

  localparam logic c_RESP_OKAY  = 1'b0;
  localparam logic c_RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_st_t;

  // Little-endian byte-lane mask for a 2^size-byte access at byte offset off.
  function automatic logic [7:0] f_lane_mask(input logic [2:0] off, input logic [1:0] size);
    logic [8:0] w_span;
    w_span = (9'd1 << (4'd1 << size)) - 9'd1;
    return w_span[7:0] << off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_array.sv
`default_nettype none
// ============================================================================
// Module  : ahb_sram_array
// Brief   : MEM_DEPTH x DATA_WIDTH SRAM, byte-enable sync write, async read.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         clk,
  input  logic                         i_we,
  input  logic [DATA_WIDTH/8-1:0]      i_be,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  output logic [DATA_WIDTH-1:0]        o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Commit only the enabled byte lanes; the other lanes keep their contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module  : ahb_sram_slave
// Brief   : AHB5 slave backed by a byte-enable SRAM, with programmable wait
//           states and a two-cycle ERROR response for illegal transfers.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic                  hwrite,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready_in,
  input  logic [2:0]            hburst,
  input  logic                  hmastlock,
  input  logic [6:0]            hprot,
  input  logic                  hnonsec,
  input  logic                  hexcl,
  input  logic [3:0]            hmaster,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp,
  output logic                  hexokay
);

  localparam int c_NBYTES = DATA_WIDTH / 8;
  localparam int c_OFF_W  = $clog2(c_NBYTES);
  localparam int c_IDX_W  = $clog2(MEM_DEPTH);
  localparam int c_LOW_W  = c_OFF_W + c_IDX_W;
  localparam logic [ADDR_WIDTH:0] c_SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * c_NBYTES);
  localparam logic [3:0] c_WS = 4'(WAIT_STATES);

  slave_st_t            r_state, w_state_nxt;
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic [c_LOW_W-1:0]   r_addr;
  logic [1:0]           r_size;
  logic                 r_write;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_err;
  logic [7:0]           w_size_mask;
  logic [7:0]           w_lane_mask;
  logic                 w_we;
  logic [c_IDX_W-1:0]   w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Only states that present hready=1 may take a new address phase.
  assign w_accept = hsel && hready_in &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ)) &&
                    ((r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2));

  assign w_size_mask = (8'd1 << hsize) - 8'd1;
  assign w_err = ({1'b0, haddr} >= c_SPAN) ||
                 (|(haddr[7:0] & w_size_mask)) ||
                 (hsize > 3'(c_OFF_W));

  // State, wait counter and data-phase registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_size  <= 2'd0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= haddr[c_LOW_W-1:0];
        r_size  <= hsize[1:0];
        r_write <= hwrite;
        r_err   <= w_err;
      end
    end
  end

  // Next-state sequencing and hready/hresp per state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    hready      = 1'b1;
    hresp       = c_RESP_OKAY;
    case (r_state)
      ST_WAIT: begin
        hready = 1'b0;
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        hready      = 1'b0;
        hresp       = c_RESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      default: begin
        // ST_IDLE, ST_DATA and ST_ERR2 are all acceptance points.
        if (r_state == ST_ERR2) begin
          hresp = c_RESP_ERROR;
        end
        if (!w_accept) begin
          w_state_nxt = ST_IDLE;
        end else if (w_err) begin
          w_state_nxt = ST_ERR1;
        end else if (WAIT_STATES == 0) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = c_WS - 4'd1;
        end
      end
    endcase
  end

  // Write commits on the edge that ends the write's data phase.
  assign w_lane_mask = f_lane_mask(3'(r_addr[c_OFF_W-1:0]), r_size);
  assign w_we        = (r_state == ST_DATA) && r_write && !r_err;
  assign w_idx       = r_addr[c_LOW_W-1:c_OFF_W];

  ahb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk     (hclk),
    .i_we    (w_we),
    .i_be    (w_lane_mask[c_NBYTES-1:0]),
    .i_addr  (w_idx),
    .i_wdata (hwdata),
    .o_rdata (w_rdata)
  );

  assign hrdata  = ((r_state == ST_DATA) && !r_write) ? w_rdata : '0;
  assign hexokay = 1'b0;

  // Sideband inputs are accepted but have no effect on this target.
  logic w_unused;
  assign w_unused = &{1'b0, hburst, hmastlock, hprot, hnonsec, hexcl, hmaster, w_lane_mask};

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ahb_sram_slave
// Brief   : Scoreboard bench for ahb_sram_slave (WAIT_STATES=0 and 3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic        use_ws3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;

  logic        hsel0, hsel1;
  logic [31:0] hrdata0, hrdata1;
  logic        hready0, hready1, hresp0, hresp1, hexokay0, hexokay1;
  logic        b_hready, b_hresp, b_hexokay;
  logic [31:0] b_hrdata;

  always #5 hclk = ~hclk;

  assign hsel0     = hsel && !use_ws3;
  assign hsel1     = hsel && use_ws3;
  assign b_hready  = use_ws3 ? hready1  : hready0;
  assign b_hresp   = use_ws3 ? hresp1   : hresp0;
  assign b_hrdata  = use_ws3 ? hrdata1  : hrdata0;
  assign b_hexokay = use_ws3 ? hexokay1 : hexokay0;

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready_in(hready0),
    .hburst(3'd0), .hmastlock(1'b0), .hprot(7'd3), .hnonsec(1'b0), .hexcl(1'b0),
    .hmaster(4'd0), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0), .hexokay(hexokay0)
  );

  ahb_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hready_in(hready1),
    .hburst(3'd0), .hmastlock(1'b0), .hprot(7'd3), .hnonsec(1'b0), .hexcl(1'b1),
    .hmaster(4'd1), .hrdata(hrdata1), .hready(hready1), .hresp(hresp1), .hexokay(hexokay1)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: tracks each address acceptance, then checks the data phase it ends with.
  logic pend = 1'b0;
  logic saw_e1 = 1'b0;
  int   cyc = 0;
  exp_t e;

  always @(negedge hclk) begin
    if (!hresetn) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        cyc++;
        if (!b_hready) begin
          if (b_hresp) saw_e1 = 1'b1;
          check("stall_hrdata", b_hrdata, 32'd0);
          if (cyc > 20) begin
            check("stall_timeout", 32'(cyc), 32'd0);
            pend = 1'b0;
          end
        end else begin
          if (q.size() == 0) begin
            check("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("hresp", 32'(b_hresp), 32'(e.err));
            check("err_first_cycle", 32'(saw_e1), 32'(e.err));
            check("latency", 32'(cyc), 32'(e.lat));
            check("hrdata", b_hrdata, e.data);
            check("hexokay", 32'(b_hexokay), 32'd0);
          end
          pend = 1'b0;
        end
      end
      if (hsel && htrans[1] && b_hready) begin
        pend   = 1'b1;
        cyc    = 0;
        saw_e1 = 1'b0;
      end
    end
  end

  // Drive one address phase (waiting for hready), push its expectation, then drive hwdata.
  task automatic issue(input logic ws3, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic err, input logic [31:0] rexp);
    int   n;
    exp_t x;
    use_ws3 = ws3;
    hsel    = 1'b1;
    haddr   = a;
    htrans  = HTRANS_NONSEQ;
    hsize   = sz;
    hwrite  = wr;
    n = 0;
    while (!b_hready && n < 50) begin
      @(posedge hclk); #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", 32'd1, 32'd0);
    x.err  = err;
    x.data = (wr || err) ? 32'd0 : rexp;
    x.lat  = err ? 2 : (ws3 ? 4 : 1);
    q.push_back(x);
    @(posedge hclk); #1;
    hwdata = wd;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || pend) && n < 100) begin
      @(posedge hclk); #1;
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    hresetn = 1'b0;
    hsel    = 1'b0;
    use_ws3 = 1'b0;
    haddr   = 32'd0;
    htrans  = HTRANS_IDLE;
    hsize   = HSIZE_WORD;
    hwrite  = 1'b0;
    hwdata  = 32'd0;
    #2;
    check("rst_hready0", 32'(hready0), 32'd1);
    check("rst_hresp0", 32'(hresp0), 32'd0);
    check("rst_hrdata0", hrdata0, 32'd0);
    check("rst_hexokay0", 32'(hexokay0), 32'd0);
    check("rst_hready1", 32'(hready1), 32'd1);
    check("rst_hrdata1", hrdata1, 32'd0);
    @(posedge hclk); @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;

    // Zero-wait slave: back-to-back write/read and sub-word lanes
    issue(0, 1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 0, 0);
    issue(0, 0, 32'h10, HSIZE_WORD, 0, 0, 32'hDEADBEEF);
    issue(0, 1, 32'h13, HSIZE_BYTE, 32'hAA000000, 0, 0);
    issue(0, 0, 32'h10, HSIZE_WORD, 0, 0, 32'hAAADBEEF);
    issue(0, 1, 32'h12, HSIZE_HALF, 32'h12340000, 0, 0);
    issue(0, 0, 32'h10, HSIZE_WORD, 0, 0, 32'h1234BEEF);
    issue(0, 0, 32'h11, HSIZE_BYTE, 0, 0, 32'h1234BEEF);
    issue(0, 1, 32'h3FC, HSIZE_WORD, 32'h0A0B0C0D, 0, 0);
    issue(0, 0, 32'h3FC, HSIZE_WORD, 0, 0, 32'h0A0B0C0D);

    // Illegal transfers leave memory untouched
    issue(0, 1, 32'h00, HSIZE_WORD, 32'h11223344, 0, 0);
    issue(0, 1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF, 1, 0);
    issue(0, 1, 32'h00, HSIZE_DWORD, 32'hFFFFFFFF, 1, 0);
    issue(0, 1, 32'h400, HSIZE_WORD, 32'h55555555, 1, 0);
    issue(0, 0, 32'h400, HSIZE_WORD, 0, 1, 0);
    issue(0, 0, 32'h00, HSIZE_WORD, 0, 0, 32'h11223344);
    drain();

    // Three wait states
    issue(1, 1, 32'h00, HSIZE_WORD, 32'hCAFEF00D, 0, 0);
    issue(1, 0, 32'h00, HSIZE_WORD, 0, 0, 32'hCAFEF00D);
    issue(1, 1, 32'h20, HSIZE_WORD, 32'h01020304, 0, 0);
    drain();

    // Reset during the wait of a write: the write must be dropped
    use_ws3 = 1'b1;
    hsel    = 1'b1;
    haddr   = 32'h20;
    htrans  = HTRANS_NONSEQ;
    hsize   = HSIZE_WORD;
    hwrite  = 1'b1;
    @(posedge hclk); #1;
    hwdata = 32'hFFFFFFFF;
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    check("wait_hready", 32'(hready1), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    check("async_rst_hready", 32'(hready1), 32'd1);
    check("async_rst_hresp", 32'(hresp1), 32'd0);
    check("async_rst_hrdata", hrdata1, 32'd0);
    check("async_rst_hexokay", 32'(hexokay1), 32'd0);
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(posedge hclk); #1;
    issue(1, 0, 32'h20, HSIZE_WORD, 0, 0, 32'h01020304);
    issue(1, 0, 32'h00, HSIZE_WORD, 0, 0, 32'hCAFEF00D);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB5 slave that consumes the transfers a master or interconnect drives onto the ahb_template slave-side port set, using the same signal set.
- Backed by a word-addressed byte-enable SRAM.
- Programmable wait states.
- Two-cycle ERROR response for illegal transfers.
- Used as the default memory target in cocotbext-ahb master/interconnect benches.

Parameters:
- ADDR_WIDTH, 32, haddr width
- DATA_WIDTH, 32, hwdata/hrdata width; legal values 32 or 64
- MEM_DEPTH, 256, number of DATA_WIDTH-bit words; byte span = MEM_DEPTH*DATA_WIDTH/8
- WAIT_STATES, 0, hready-low cycles inserted in every OKAY data phase; range 0..15

Ports:
- hclk in 1: clock
- hresetn in 1: reset, asynchronous, active-low
- hsel in 1: slave select
- haddr in ADDR_WIDTH: byte address
- htrans in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- hsize in 3: transfer size, log2 bytes
- hwrite in 1: 1=write
- hwdata in DATA_WIDTH: write data, data phase
- hready_in in 1: bus-level ready
- hburst, hmastlock, hprot, hnonsec, hexcl, hmaster in 3/1/7/1/1/4: accepted and ignored
- hrdata out DATA_WIDTH: read data
- hready out 1: transfer done
- hresp out 1: 0=OKAY, 1=ERROR
- hexokay out 1: always 0 (exclusives unsupported)

Behaviour:
- Clock and reset: one clock hclk; reset hresetn is asynchronous, active-low.
- Reset values: hready=1, hresp=0, hrdata=0, hexokay=0, FSM=ST_IDLE, wait counter=0. Memory contents are not reset.
- Address phase is accepted on a rising edge only when hsel & hready_in & htrans[1]. On acceptance, latch addr, size, write and error flag into the data-phase registers.
- IDLE/BUSY selected, or no select: zero-wait OKAY response, no memory access.
- Error when any of these holds:
  - addr >= byte span
  - addr not aligned to 2^hsize
  - 2^hsize > DATA_WIDTH/8
- ST_IDLE: hready=1, hresp=0.
  - Accepted legal transfer, WAIT_STATES=0: next cycle is ST_DATA.
  - Accepted legal transfer, WAIT_STATES>0: next cycle is ST_WAIT, counter=WAIT_STATES-1.
  - Accepted error transfer: next cycle is ST_ERR1.
- ST_WAIT: hready=0, hresp=0. Counter decrements each cycle; at 0 go to ST_DATA.
- ST_DATA: hready=1, hresp=0; transfer completes.
  - Same-edge pipelined acceptance is allowed (back-to-back).
  - If a new transfer is accepted, follow the ST_IDLE rules from that edge; otherwise go to ST_IDLE.
- ST_ERR1: hready=0, hresp=1, then ST_ERR2.
- ST_ERR2: hready=1, hresp=1. It is an address-phase acceptance point, like ST_DATA. Per AHB the master may cancel by driving IDLE.
- Write commit:
  - Memory is written on the edge ending ST_DATA of a write, never earlier.
  - Byte lanes are selected by addr[log2(DATA_WIDTH/8)-1:0] and size, little-endian.
  - Unselected lanes are unchanged.
- Read data:
  - hrdata is driven combinationally from the array at the latched word index during ST_DATA of a read; 0 in every other state.
  - Full word is returned; the master extracts the lanes.
  - Read-after-write to the same address, back-to-back, returns the new data because the commit precedes the read data phase.
- Latency: a legal transfer completes (hready=1) WAIT_STATES+1 cycles after address acceptance.
- Ignored and unsupported:
  - hsel is not examined during data/wait phases.
  - Bursts are treated as independent single transfers; wrap/incr are irrelevant.
  - hmastlock/hprot/hexcl are not acted on.
  - An exclusive access is performed as a normal access with hexokay=0.
- Reset mid-transfer:
  - Asynchronous return to the reset values.
  - A pending write is dropped, with no partial commit.
  - hready reads 1 immediately.

Decomposition:
- Shared package ahb_pkg:
  - htrans_t (IDLE/BUSY/NONSEQ/SEQ)
  - hsize_t (BYTE..DWORD)
  - resp constants OKAY/ERROR
  - slave_st_t {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2}
- Sub-module ahb_sram_array:
  - MEM_DEPTH x DATA_WIDTH
  - synchronous byte-enable write port
  - asynchronous read port
  - no reset

Test Plan:
- WAIT_STATES=0, NONSEQ word write 0xDEADBEEF @0x10 followed directly by a word read @0x10: hready stays 1, hresp=0, and the read data phase gives hrdata=0xDEADBEEF.
- Byte write 0xAA @0x13 then word read @0x10: hrdata=0xAAADBEEF; halfword write 0x1234 @0x12 gives 0x1234BEEF.
- WAIT_STATES=3, word read @0x0: hready low for exactly 3 cycles, then high for 1 cycle; completion 4 cycles after acceptance.
- Out-of-range read @0x400 (MEM_DEPTH=256): ST_ERR1 gives hready=0, hresp=1, then ST_ERR2 gives hready=1, hresp=1; memory unchanged.
- Misaligned word write @0x02 and hsize=3 on a 32-bit bus: each gets a two-cycle ERROR, and a read of 0x00 shows the old data.
- hresetn pulsed low during ST_WAIT of a write to 0x20: outputs return to the reset values asynchronously, and a later read of 0x20 returns the pre-write contents.
